// File: rtl/seg7_pkg.sv
// Shared 7-segment constants for the NVBoard display drivers.
// Patterns are active-low: bit7=a .. bit1=g, bit0=dp.
package seg7_pkg;

  localparam logic [7:0] SEG_HEX [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  localparam logic [7:0] SEG_DASH  = 8'hFD;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int         DP_BIT    = 0;

endpackage

// File: rtl/prio_enc_disp_if.sv
// Request/response bundle of the priority encoder with display.
// The master side drives the requests and controls; the slave side returns the encoder results.
interface prio_enc_disp_if #(
  parameter int N_IN  = 8,
  parameter int CNT_W = 8
);

  localparam int IDX_W   = $clog2(N_IN);
  localparam int IDX_DIG = (IDX_W + 3) / 4;
  localparam int CNT_DIG = CNT_W / 4;
  localparam int SEG_W   = (IDX_DIG + CNT_DIG) * 8;

  logic [N_IN-1:0]  a;
  logic             en;
  logic             freeze;
  logic             clr_cnt;
  logic [IDX_W-1:0] idx;
  logic             valid;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [SEG_W-1:0] seg;

  modport master (
    output a, en, freeze, clr_cnt,
    input  idx, valid, cnt, ovf, seg
  );

  modport slave (
    input  a, en, freeze, clr_cnt,
    output idx, valid, cnt, ovf, seg
  );

endinterface

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to active-low 7-segment pattern, with optional decimal point.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp_on,
  output logic [7:0] pattern
);

  always_comb begin
    pattern         = SEG_HEX[nibble];
    pattern[DP_BIT] = ~dp_on;
  end

endmodule

// File: rtl/prio_enc_disp.sv
// Registered priority encoder that counts new-winner events and shows the index and the count
// on active-low hex digits (index in the low digits, count in the high digits).
module prio_enc_disp
  import seg7_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  prio_enc_disp_if.slave bus
);

  localparam int IDX_W   = $clog2(N_IN);
  localparam int IDX_DIG = (IDX_W + 3) / 4;
  localparam int CNT_DIG = CNT_W / 4;
  localparam int N_DIG   = IDX_DIG + CNT_DIG;
  localparam int SEG_W   = N_DIG * 8;

  logic [IDX_W-1:0]     idx_q;
  logic                 valid_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_q;
  logic [SEG_W-1:0]     seg_q;
  logic [IDX_W-1:0]     idx_n;
  logic                 valid_n;
  logic                 win_event;
  logic [IDX_DIG*4-1:0] idx_pad;
  logic [7:0]           dec_pat [N_DIG];
  logic [SEG_W-1:0]     seg_n;

  // Ascending scan so the highest set bit is the last one to overwrite the result
  function automatic logic [IDX_W-1:0] encode(input logic [N_IN-1:0] req);
    encode = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (req[i]) encode = IDX_W'(i);
    end
  endfunction

  always_comb begin
    valid_n   = bus.en && (bus.a != '0);
    idx_n     = valid_n ? encode(bus.a) : '0;
    win_event = valid_n && (!valid_q || (idx_n != idx_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (!bus.freeze) begin
      idx_q   <= idx_n;
      valid_q <= valid_n;
    end
  end

  // A clear on the same cycle as an event wins; the event is simply lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (!bus.freeze) begin
      if (bus.clr_cnt) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (win_event) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == '1) ovf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    idx_pad              = '0;
    idx_pad[IDX_W-1:0]   = idx_q;
  end

  for (genvar d = 0; d < IDX_DIG; d++) begin : g_idx_dig
    seg7_hex_dec u_dec (
      .nibble  (idx_pad[4*d +: 4]),
      .dp_on   (1'b0),
      .pattern (dec_pat[d])
    );
  end

  // Only the most significant count digit carries the overflow point
  for (genvar j = 0; j < CNT_DIG; j++) begin : g_cnt_dig
    seg7_hex_dec u_dec (
      .nibble  (cnt_q[4*j +: 4]),
      .dp_on   ((j == CNT_DIG - 1) && ovf_q),
      .pattern (dec_pat[IDX_DIG + j])
    );
  end

  always_comb begin
    seg_n = '0;
    for (int d = 0; d < N_DIG; d++) begin
      if ((d < IDX_DIG) && !valid_q) seg_n[8*d +: 8] = SEG_DASH;
      else                           seg_n[8*d +: 8] = dec_pat[d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           seg_q <= {N_DIG{SEG_BLANK}};
    else if (!bus.freeze) seg_q <= seg_n;
  end

  assign bus.idx   = idx_q;
  assign bus.valid = valid_q;
  assign bus.cnt   = cnt_q;
  assign bus.ovf   = ovf_q;
  assign bus.seg   = seg_q;

endmodule

// File: tb/tb_prio_enc_disp.sv
// Self-checking bench for prio_enc_disp: directed scenarios plus randomized traffic against a
// cycle-level reference model of the encoder, event counter and display.
module tb_prio_enc_disp;

  localparam int N_IN    = 8;
  localparam int CNT_W   = 8;
  localparam int IDX_W   = $clog2(N_IN);
  localparam int IDX_DIG = (IDX_W + 3) / 4;
  localparam int CNT_DIG = CNT_W / 4;
  localparam int SEG_W   = (IDX_DIG + CNT_DIG) * 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [7:0] HEX_TAB [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  int               m_idx;
  bit               m_valid;
  int               m_cnt;
  bit               m_ovf;
  logic [SEG_W-1:0] m_seg;

  prio_enc_disp_if #(.N_IN(N_IN), .CNT_W(CNT_W)) bus ();

  prio_enc_disp #(.N_IN(N_IN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Position of the highest set bit as floor(log2(v))
  function automatic int high_bit(input logic [N_IN-1:0] v);
    int p;
    logic [N_IN-1:0] t;
    p = 0;
    t = v;
    while (t > 1) begin
      t = t >> 1;
      p++;
    end
    return p;
  endfunction

  function automatic logic [SEG_W-1:0] disp(input int idx, input bit valid, input int cnt,
                                            input bit ovf);
    logic [SEG_W-1:0] s;
    logic [7:0] p;
    s = '0;
    for (int d = 0; d < IDX_DIG; d++)
      s[8*d +: 8] = valid ? HEX_TAB[(idx >> (4*d)) & 15] : 8'hFD;
    for (int j = 0; j < CNT_DIG; j++) begin
      p = HEX_TAB[(cnt >> (4*j)) & 15];
      if ((j == CNT_DIG - 1) && ovf) p[0] = 1'b0;
      s[8*(IDX_DIG+j) +: 8] = p;
    end
    return s;
  endfunction

  // Reference model: display follows the previous cycle's encoder/counter state
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idx   <= 0;
      m_valid <= 1'b0;
      m_cnt   <= 0;
      m_ovf   <= 1'b0;
      m_seg   <= '1;
    end else if (!bus.freeze) begin
      m_seg <= disp(m_idx, m_valid, m_cnt, m_ovf);
      if (bus.en && (bus.a != 0)) begin
        m_idx   <= high_bit(bus.a);
        m_valid <= 1'b1;
      end else begin
        m_idx   <= 0;
        m_valid <= 1'b0;
      end
      if (bus.clr_cnt) begin
        m_cnt <= 0;
        m_ovf <= 1'b0;
      end else if (bus.en && (bus.a != 0) && (!m_valid || (high_bit(bus.a) != m_idx))) begin
        if (m_cnt == CNT_MAX) begin
          m_cnt <= 0;
          m_ovf <= 1'b1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.a = '0; bus.en = 1'b1; bus.freeze = 1'b0; bus.clr_cnt = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.seg !== 24'hFFFFFF) begin
      errors++; $display("[TB] FAIL reset_seg: got %h expected %h", bus.seg, 24'hFFFFFF);
    end
    checks++;
    if (bus.cnt !== 8'h00 || bus.ovf !== 1'b0 || bus.valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_state: got cnt=%h ovf=%b valid=%b expected 00 0 0",
                         bus.cnt, bus.ovf, bus.valid);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.seg !== 24'h0303FD) begin
      errors++; $display("[TB] FAIL reset_release_seg: got %h expected %h", bus.seg, 24'h0303FD);
    end
  endtask

  task automatic test_encode();
    bus.a = 8'b0010_0110;
    tick();
    checks++;
    if (bus.idx !== 3'd5 || bus.valid !== 1'b1 || bus.cnt !== 8'd1) begin
      errors++; $display("[TB] FAIL encode_first: got idx=%0d valid=%b cnt=%0d expected 5 1 1",
                         bus.idx, bus.valid, bus.cnt);
    end
    tick();
    checks++;
    if (bus.seg !== 24'h039F49) begin
      errors++; $display("[TB] FAIL encode_seg: got %h expected %h", bus.seg, 24'h039F49);
    end
  endtask

  task automatic test_hold_and_change();
    repeat (10) tick();
    checks++;
    if (bus.cnt !== 8'd1) begin
      errors++; $display("[TB] FAIL hold_count: got %0d expected 1", bus.cnt);
    end
    bus.a = 8'h80;
    tick();
    checks++;
    if (bus.idx !== 3'd7 || bus.cnt !== 8'd2) begin
      errors++; $display("[TB] FAIL new_winner: got idx=%0d cnt=%0d expected 7 2", bus.idx, bus.cnt);
    end
    bus.en = 1'b0;
    tick();
    checks++;
    if (bus.valid !== 1'b0 || bus.idx !== 3'd0) begin
      errors++; $display("[TB] FAIL disable: got valid=%b idx=%0d expected 0 0", bus.valid, bus.idx);
    end
    tick();
    checks++;
    if (bus.seg[7:0] !== 8'hFD) begin
      errors++; $display("[TB] FAIL dash_digit: got %h expected fd", bus.seg[7:0]);
    end
    bus.en = 1'b1;
    tick();
    checks++;
    if (bus.cnt !== 8'd3) begin
      errors++; $display("[TB] FAIL revalid_count: got %0d expected 3", bus.cnt);
    end
  endtask

  task automatic test_freeze_clr();
    bus.freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.a = N_IN'($urandom);
      bus.en = 1'(i);
      tick();
      checks++;
      if (bus.idx !== 3'd7 || bus.valid !== 1'b1 || bus.cnt !== 8'd3 ||
          bus.seg !== m_seg) begin
        errors++; $display("[TB] FAIL freeze_hold: got idx=%0d valid=%b cnt=%0d seg=%h expected 7 1 3 %h",
                           bus.idx, bus.valid, bus.cnt, bus.seg, m_seg);
      end
    end
    bus.freeze = 1'b0; bus.en = 1'b1; bus.a = 8'h01; bus.clr_cnt = 1'b1;
    tick();
    bus.clr_cnt = 1'b0;
    checks++;
    if (bus.cnt !== 8'd0 || bus.ovf !== 1'b0 || bus.idx !== 3'd0 || bus.valid !== 1'b1) begin
      errors++; $display("[TB] FAIL clr_with_event: got cnt=%0d ovf=%b idx=%0d valid=%b expected 0 0 0 1",
                         bus.cnt, bus.ovf, bus.idx, bus.valid);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) begin
      bus.a = (i % 2 == 0) ? 8'h02 : 8'h01;
      tick();
    end
    checks++;
    if (bus.cnt !== 8'd0 || bus.ovf !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap: got cnt=%0d ovf=%b expected 0 1", bus.cnt, bus.ovf);
    end
    tick();
    checks++;
    if (bus.seg[16] !== 1'b0 || bus.seg[23:17] !== 7'h01) begin
      errors++; $display("[TB] FAIL wrap_dp: got seg[23:16]=%h expected 02", bus.seg[23:16]);
    end
    bus.clr_cnt = 1'b1;
    tick();
    bus.clr_cnt = 1'b0;
    checks++;
    if (bus.ovf !== 1'b0 || bus.cnt !== 8'd0) begin
      errors++; $display("[TB] FAIL ovf_clear: got ovf=%b cnt=%0d expected 0 0", bus.ovf, bus.cnt);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 42; i++) begin
      bus.a = (i % 2 == 0) ? 8'h02 : 8'h01;
      tick();
    end
    checks++;
    if (bus.cnt !== 8'h2A) begin
      errors++; $display("[TB] FAIL pre_reset_count: got %h expected 2a", bus.cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.cnt !== 8'h00 || bus.ovf !== 1'b0 || bus.valid !== 1'b0 || bus.idx !== 3'd0 ||
        bus.seg !== 24'hFFFFFF) begin
      errors++; $display("[TB] FAIL async_reset: got cnt=%h ovf=%b valid=%b idx=%0d seg=%h expected 00 0 0 0 ffffff",
                         bus.cnt, bus.ovf, bus.valid, bus.idx, bus.seg);
    end
    #2;
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.seg !== 24'h0303FD) begin
      errors++; $display("[TB] FAIL post_reset_seg: got %h expected %h", bus.seg, 24'h0303FD);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       bus.a = '0;
        1:       bus.a = N_IN'(1) << $urandom_range(0, N_IN - 1);
        default: bus.a = N_IN'($urandom);
      endcase
      bus.en      = ($urandom_range(0, 9) != 0);
      bus.freeze  = ($urandom_range(0, 9) == 0);
      bus.clr_cnt = ($urandom_range(0, 29) == 0);
      tick();
      checks++;
      if (int'(bus.idx) !== m_idx || bus.valid !== m_valid || int'(bus.cnt) !== m_cnt ||
          bus.ovf !== m_ovf || bus.seg !== m_seg) begin
        errors++; $display("[TB] FAIL random_%0d: got idx=%0d valid=%b cnt=%0d ovf=%b seg=%h expected %0d %b %0d %b %h",
                           i, bus.idx, bus.valid, bus.cnt, bus.ovf, bus.seg,
                           m_idx, m_valid, m_cnt, m_ovf, m_seg);
      end
    end
    bus.freeze = 1'b0; bus.clr_cnt = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_encode();
    test_hold_and_change();
    test_freeze_clr();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
